// File: rtl/dma_csr_ctrl.sv
// -----------------------------------------------------------------------------
// dma_csr_ctrl
//   AXI4-Lite control/status front-end for a simple DMA engine. The host
//   programs SRC, DST and LEN, then writes CTRL.START. The block emits a
//   one-cycle trigger with stable src_addr/dest_addr/length, tracks busy/done,
//   counts completed transfers and answers illegal accesses with SLVERR.
//
//   Optional feature macro: DMA_CSR_IRQ_EN
//     defined   : adds output irq = STATUS.DONE & CTRL.IRQ_ENABLE (CTRL bit1),
//                 CTRL bit1 is stored and readable, STATUS bit2 reads irq.
//     undefined : no irq port, CTRL bit1 ignored (reads 0), STATUS bit2 reads 0.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   AW*/W*/B*                     AXI4-Lite write address/data/response
//   AR*/R*                        AXI4-Lite read address/data
//   trigger                       one-cycle start pulse to the DMA
//   src_addr, dest_addr, length   transfer descriptor, mirrors SRC/DST/LEN
//   done                          DMA completion (level or pulse, rising edge)
//   irq                           only with DMA_CSR_IRQ_EN
//
// Register map (word index = addr[4:2])
//   0 SRC | 1 DST | 2 LEN | 3 CTRL | 4 STATUS | 5 COUNT | 6,7 unmapped (SLVERR)
//
// DMA FSM states
//   state   | meaning
//   IDLE    | no transfer in flight, START accepted if LEN != 0
//   BUSY    | transfer running, descriptor registers locked until done rises
// -----------------------------------------------------------------------------
module dma_csr_ctrl #(
  parameter int LEN_W   = 6,
  parameter int COUNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [31:0]       ARADDR,
  input  logic [2:0]        ARPROT,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              trigger,
  output logic [31:0]       src_addr,
  output logic [31:0]       dest_addr,
  output logic [LEN_W-1:0]  length,
  input  logic              done
`ifdef DMA_CSR_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] A_SRC    = 3'd0;
  localparam logic [2:0] A_DST    = 3'd1;
  localparam logic [2:0] A_LEN    = 3'd2;
  localparam logic [2:0] A_CTRL   = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_COUNT  = 3'd5;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e             state_q, state_d;
  logic               awready_q, awready_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic               trigger_q, trigger_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               done_flag_q, done_flag_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               done_prev_q;

  logic               wr_acc;
  logic               rd_acc;
  logic               busy;
  logic               done_rise;
  logic               start_req;
  logic               irq_bit;
  logic               ctrl_irq_en_rd;

`ifdef DMA_CSR_IRQ_EN
  logic               irq_en_q, irq_en_d;
  assign irq_bit        = done_flag_q & irq_en_q;
  assign ctrl_irq_en_rd = irq_en_q;
  assign irq            = irq_bit;
`else
  assign irq_bit        = 1'b0;
  assign ctrl_irq_en_rd = 1'b0;
`endif

  // Address bits outside the decode window and the protection fields are
  // intentionally ignored.
  logic unused_sigs;
  assign unused_sigs = ^{AWADDR[31:5], AWADDR[1:0], ARADDR[31:5], ARADDR[1:0],
                         AWPROT, ARPROT};

  // Byte-lane merge: lanes whose strobe is low keep their old contents.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // READY is raised one cycle after both valids are seen and the previous
  // response has drained; the transaction is consumed while READY is high.
  assign wr_acc    = awready_q & AWVALID & WVALID;
  assign rd_acc    = arready_q & ARVALID;
  assign busy      = (state_q == ST_BUSY);
  assign done_rise = done & ~done_prev_q;
  assign start_req = WSTRB[0] & WDATA[0];

  always_comb begin
    state_d     = state_q;
    awready_d   = AWVALID & WVALID & ~bvalid_q & ~awready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    arready_d   = ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    trigger_d   = 1'b0;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    done_flag_d = done_flag_q;
    count_d     = count_q;
`ifdef DMA_CSR_IRQ_EN
    irq_en_d    = irq_en_q;
`endif

    if (bvalid_q && BREADY) bvalid_d = 1'b0;
    if (rvalid_q && RREADY) rvalid_d = 1'b0;

    if (wr_acc) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (AWADDR[4:2])
        A_SRC: begin
          if (busy) bresp_d = RESP_SLVERR;
          else      src_d   = apply_strb(src_q, WDATA, WSTRB);
        end
        A_DST: begin
          if (busy) bresp_d = RESP_SLVERR;
          else      dst_d   = apply_strb(dst_q, WDATA, WSTRB);
        end
        A_LEN: begin
          if (busy) begin
            bresp_d = RESP_SLVERR;
          end else begin
            for (int i = 0; i < LEN_W; i++) begin
              if (WSTRB[i/8]) len_d[i] = WDATA[i];
            end
          end
        end
        A_CTRL: begin
          if (start_req && (busy || len_q == '0)) begin
            bresp_d = RESP_SLVERR;
          end else begin
            if (start_req) begin
              state_d     = ST_BUSY;
              trigger_d   = 1'b1;
              done_flag_d = 1'b0;
            end
`ifdef DMA_CSR_IRQ_EN
            if (WSTRB[0]) irq_en_d = WDATA[1];
`endif
          end
        end
        A_STATUS: begin
          if (WSTRB[0] && WDATA[1]) done_flag_d = 1'b0;
        end
        A_COUNT: begin
          // read-only; write acknowledged without effect
        end
        default: bresp_d = RESP_SLVERR;
      endcase
    end

    // Evaluated after the write decode so a completion wins over a
    // same-cycle W1C of DONE.
    if (busy && done_rise) begin
      state_d     = ST_IDLE;
      done_flag_d = 1'b1;
      count_d     = count_q + COUNT_W'(1);
    end

    if (rd_acc) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      case (ARADDR[4:2])
        A_SRC:    rdata_d = src_q;
        A_DST:    rdata_d = dst_q;
        A_LEN:    rdata_d = 32'(len_q);
        A_CTRL:   rdata_d = {30'd0, ctrl_irq_en_rd, 1'b0};
        A_STATUS: rdata_d = {29'd0, irq_bit, done_flag_q, busy};
        A_COUNT:  rdata_d = 32'(count_q);
        default:  rresp_d = RESP_SLVERR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      trigger_q   <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      done_flag_q <= 1'b0;
      count_q     <= '0;
      done_prev_q <= 1'b0;
`ifdef DMA_CSR_IRQ_EN
      irq_en_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      trigger_q   <= trigger_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      done_flag_q <= done_flag_d;
      count_q     <= count_d;
      done_prev_q <= done;
`ifdef DMA_CSR_IRQ_EN
      irq_en_q    <= irq_en_d;
`endif
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = awready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign trigger   = trigger_q;
  assign src_addr  = src_q;
  assign dest_addr = dst_q;
  assign length    = len_q;

endmodule
